m_ext_sequencer: RTL

Issue/retire controller for the RV32M unit in the execute stage, sitting between the pipeline and the shared shift-add multiplier/divider core.
- Decodes funct3, sign- or zero-extends rs1/rs2 to 33 bits, launches the core and waits for its response.
- Selects the low/high product word or the quotient/remainder.
- Resolves divide-by-zero and signed overflow locally, without launching the core.
- Stalls the pipeline until the result is valid.

---
 rtl/m_ext_pkg.sv | 29 ++
 rtl/m_ext_resolve.sv | 72 +++++++
 rtl/m_ext_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/m_ext_pkg.sv
// rtl/m_ext_pkg.sv - shared types and constants for the RV32M sequencer
// Purpose: funct3 operation encodings, sequencer state encoding and the
//          architectural constants used by the divide special cases.
// Ports:   none (package).
package m_ext_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  // Quotient returned for any divide by zero.
  localparam logic [31:0] DIV_ZERO_Q = '1;
  // Most negative 32-bit value; DIV INT_MIN / -1 overflows to itself.
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

endpackage

// File: rtl/m_ext_resolve.sv
// rtl/m_ext_resolve.sv - combinational operand extension, special cases and result select
// Purpose: extends rs1/rs2 to XLEN+1 bits for the core, detects the divide
//          cases resolved without the core (and their values), and picks
//          the architectural result out of the core's {Aval, Bval} pair.
// Ports:   funct3      operation
//          rs1, rs2    architectural operands
//          aval, bval  core high half / remainder, low half / quotient
//          op_a, op_b  extended core operands
//          special     divide by zero or signed overflow
//          bypass      result for the special case
//          sel_result  result selected from aval/bval
module m_ext_resolve
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN:0]   aval,
  input  logic [XLEN:0]   bval,
  output logic [XLEN:0]   op_a,
  output logic [XLEN:0]   op_b,
  output logic            special,
  output logic [XLEN-1:0] bypass,
  output logic [XLEN-1:0] sel_result
);

  m_op_t op;
  logic  sgn_a;
  logic  sgn_b;
  logic  div_zero;
  logic  div_ovf;
  logic  unused_aval_msb;

  assign op = m_op_t'(funct3);

  // rs1 is signed for everything except the unsigned-only forms; rs2 is
  // signed only where both operands are signed.
  assign sgn_a = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
  assign sgn_b = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);

  assign op_a = {sgn_a & rs1[XLEN-1], rs1};
  assign op_b = {sgn_b & rs2[XLEN-1], rs2};

  // funct3[2] marks divide/remainder, funct3[1] remainder, funct3[0] unsigned.
  assign div_zero = funct3[2] && (rs2 == '0);
  assign div_ovf  = funct3[2] && !funct3[0] && (rs1 == INT_MIN) && (rs2 == '1);
  assign special  = div_zero || div_ovf;

  always_comb begin
    bypass = '0;
    if (div_zero) begin
      bypass = funct3[1] ? rs1 : DIV_ZERO_Q;
    end else if (div_ovf) begin
      bypass = funct3[1] ? '0 : INT_MIN;
    end
  end

  // The product spans {aval, bval}; its upper word straddles the two halves.
  always_comb begin
    sel_result = aval[XLEN-1:0];
    case (op)
      OP_MUL, OP_DIV, OP_DIVU:      sel_result = bval[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: sel_result = {aval[XLEN-2:0], bval[XLEN]};
      default:                      sel_result = aval[XLEN-1:0];
    endcase
  end

  assign unused_aval_msb = aval[XLEN];

endmodule

// File: rtl/m_ext_sequencer.sv
// rtl/m_ext_sequencer.sv - RV32M issue/retire sequencer for the shared mul/div core
// Purpose: launches the shift-add core for MUL*/DIV*/REM* instructions in EX,
//          resolves divide corner cases locally and stalls the pipeline
//          until the result is valid.
// Ports:   clk, rst                 clock, asynchronous active-high reset
//          req_valid, funct3        M instruction present in EX and its op
//          rs1, rs2                 operands (stable while stalled)
//          hold                     downstream stall, freezes core and result
//          stall_o                  stall request to the pipeline
//          result_valid, result     rd write data
//          mul_run/opA/opB/div      core launch interface
//          mul_stall                core freeze (= hold)
//          mul_Aval/Bval/resp/ready core response interface
// Option:  MULDIV_RESULT_REUSE_EN keeps the last core result so that a
//          request with identical extended operands and divide flag
//          (MULH+MUL, DIV+REM pairs) completes without relaunching.
module m_ext_sequencer
  import m_ext_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            hold,
  output logic            stall_o,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic            mul_run,
  output logic [XLEN:0]   mul_opA,
  output logic [XLEN:0]   mul_opB,
  output logic            mul_div,
  output logic            mul_stall,
  input  logic [XLEN:0]   mul_Aval,
  input  logic [XLEN:0]   mul_Bval,
  input  logic            mul_resp,
  input  logic            mul_ready
);

  seq_state_t      state;
  logic            flushed;
  logic [XLEN:0]   op_a;
  logic [XLEN:0]   op_b;
  logic            special;
  logic [XLEN-1:0] bypass;
  logic [XLEN-1:0] sel_result;
  logic [XLEN:0]   sel_aval;
  logic [XLEN:0]   sel_bval;
  logic            reuse_hit;
  logic            core_done;
  logic            discard;

  m_ext_resolve #(.XLEN(XLEN)) u_resolve (
    .funct3     (funct3),
    .rs1        (rs1),
    .rs2        (rs2),
    .aval       (sel_aval),
    .bval       (sel_bval),
    .op_a       (op_a),
    .op_b       (op_b),
    .special    (special),
    .bypass     (bypass),
    .sel_result (sel_result)
  );

  assign core_done = (state == S_RUN) && mul_resp;
  // Once req_valid has dropped during RUN the instruction was flushed; the
  // core still runs to completion but its answer belongs to nobody.
  assign discard   = flushed || !req_valid;

  assign stall_o   = req_valid && (state != S_DONE) && !rst;
  assign mul_stall = hold;

`ifdef MULDIV_RESULT_REUSE_EN
  logic          cache_valid;
  logic          cache_div;
  logic [XLEN:0] cache_a;
  logic [XLEN:0] cache_b;
  logic [XLEN:0] cache_aval;
  logic [XLEN:0] cache_bval;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_valid <= 1'b0;
      cache_div   <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_aval  <= '0;
      cache_bval  <= '0;
    end else if (core_done) begin
      if (discard) begin
        cache_valid <= 1'b0;
      end else begin
        cache_valid <= 1'b1;
        cache_div   <= mul_div;
        cache_a     <= mul_opA;
        cache_b     <= mul_opB;
        cache_aval  <= mul_Aval;
        cache_bval  <= mul_Bval;
      end
    end
  end

  assign reuse_hit = cache_valid && (op_a == cache_a) && (op_b == cache_b) &&
                     (funct3[2] == cache_div);
  // In IDLE the selector re-reads the cached pair for the new funct3.
  assign sel_aval  = (state == S_RUN) ? mul_Aval : cache_aval;
  assign sel_bval  = (state == S_RUN) ? mul_Bval : cache_bval;
`else
  assign reuse_hit = 1'b0;
  assign sel_aval  = mul_Aval;
  assign sel_bval  = mul_Bval;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      flushed      <= 1'b0;
      mul_run      <= 1'b0;
      mul_div      <= 1'b0;
      mul_opA      <= '0;
      mul_opB      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (special) begin
              result       <= bypass;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else if (reuse_hit) begin
              result       <= sel_result;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end else if (mul_ready) begin
              mul_opA <= op_a;
              mul_opB <= op_b;
              mul_div <= funct3[2];
              mul_run <= 1'b1;
              flushed <= 1'b0;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (mul_resp) begin
            mul_run <= 1'b0;
            if (discard) begin
              state <= S_IDLE;
            end else begin
              result       <= sel_result;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end
          end else if (!req_valid) begin
            flushed <= 1'b1;
          end
        end
        S_DONE: begin
          // mul_run is already low here, so every launch is a fresh rising edge.
          if (!hold) begin
            result_valid <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
